// File: rtl/div_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_if
// Description : Request/response bundle between the EX stage and the
//               sequential divider (operands, control, result, stall).
// Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_if #(
    parameter int DATA_W = 32
);
    logic                  start_i;
    logic                  annul_i;
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stall_req_o;

    // Pipeline side: issues requests, consumes the result
    modport master (
        output start_i,
        output annul_i,
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        input  result_o,
        input  ready_o,
        input  stall_req_o
    );

    // Divider side
    modport slave (
        input  start_i,
        input  annul_i,
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        output result_o,
        output ready_o,
        output stall_req_o
    );
endinterface
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : Multi-cycle restoring divider (DIV / DIVU), one quotient bit
//               per cycle, result {remainder, quotient}, with annul support.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int DATA_W = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,     // asynchronous, active-low
    div_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [1:0] S_FREE    = 2'd0;
    localparam logic [1:0] S_BY_ZERO = 2'd1;
    localparam logic [1:0] S_ON      = 2'd2;
    localparam logic [1:0] S_END     = 2'd3;

    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;     // partial remainder
    logic [DATA_W-1:0]   quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]   dvs_q, dvs_d;     // divisor magnitude
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                w_accept;
    logic                w_div_zero;
    logic [DATA_W-1:0]   w_mag1;
    logic [DATA_W-1:0]   w_mag2;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_rem_step;
    logic [DATA_W-1:0]   w_quo_step;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [DATA_W-1:0]   w_quo_fix;
    logic                w_stall;

    // A request is taken only when it is not being flushed in the same cycle
    assign w_accept   = bus.start_i && !bus.annul_i;
    assign w_div_zero = (bus.opdata2_i == '0);

    // Operand magnitudes: negate negative operands in signed mode
    assign w_mag1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? (~bus.opdata1_i + 1'b1)
                                                                    : bus.opdata1_i;
    assign w_mag2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? (~bus.opdata2_i + 1'b1)
                                                                    : bus.opdata2_i;

    // One restoring step; the difference is kept DATA_W+1 bits so its MSB is the borrow
    assign w_shift    = {rem_q, quo_q[DATA_W-1]};
    assign w_diff     = w_shift - {1'b0, dvs_q};
    assign w_rem_step = w_diff[DATA_W] ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
    assign w_quo_step = {quo_q[DATA_W-2:0], ~w_diff[DATA_W]};

    // Sign fixup on the final step: truncating division, remainder follows dividend
    assign w_quo_fix = neg_quo_q ? (~w_quo_step + 1'b1) : w_quo_step;
    assign w_rem_fix = neg_rem_q ? (~w_rem_step + 1'b1) : w_rem_step;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FREE: begin
                if (w_accept) begin
                    state_d = w_div_zero ? S_BY_ZERO : S_ON;
                end
            end
            S_BY_ZERO: begin
                state_d = bus.annul_i ? S_FREE : S_END;
            end
            S_ON: begin
                if (bus.annul_i) begin
                    state_d = S_FREE;
                end else if (cnt_q == C_LAST_STEP) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                if (!bus.start_i) begin
                    state_d = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    // FSM outputs: stall the pipeline while a divide is requested or running
    always_comb begin
        w_stall = 1'b0;
        if (rst && !bus.annul_i) begin
            case (state_q)
                S_FREE:    w_stall = bus.start_i;
                S_BY_ZERO: w_stall = 1'b1;
                S_ON:      w_stall = 1'b1;
                default:   w_stall = 1'b0;
            endcase
        end
    end

    // Datapath next-state: operand capture, iteration, result load/clear
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            S_FREE: begin
                if (w_accept && !w_div_zero) begin
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = w_mag1;
                    dvs_d     = w_mag2;
                    neg_quo_d = bus.signed_div_i &&
                                (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                    neg_rem_d = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
                end
            end
            S_BY_ZERO: begin
                if (!bus.annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            S_ON: begin
                if (!bus.annul_i) begin
                    rem_d = w_rem_step;
                    quo_d = w_quo_step;
                    cnt_d = cnt_q + C_CNT_ONE;
                    if (cnt_q == C_LAST_STEP) begin
                        cnt_d    = cnt_q;
                        result_d = {w_rem_fix, w_quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end
            S_END: begin
                if (!bus.start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o    = result_q;
    assign bus.ready_o     = ready_q;
    assign bus.stall_req_o = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq
// Description : Directed self-checking bench for div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    localparam int DATA_W = 32;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    div_seq_if #(.DATA_W(DATA_W)) bus();

    div_seq #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one divide from a negedge, scramble inputs after sampling,
    // check latency, result, hold in END and clear on release.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        bus.start_i      = 1'b1;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        #1;
        chk({tag, ".stall_req"}, 64'(bus.stall_req_o), 64'd1);
        @(posedge clk);
        #1;
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sgn;
        n = 0;
        while (!bus.ready_o && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(lat));
        chk({tag, ".result"}, bus.result_o, exp);
        chk({tag, ".stall_end"}, 64'(bus.stall_req_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ".hold"}, {bus.result_o[62:0], bus.ready_o}, {exp[62:0], 1'b1});
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".clear"}, {bus.result_o[62:0], bus.ready_o}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int rises;
        errors = 0;
        checks = 0;
        rst              = 1'b0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        #2;
        chk("reset.result", bus.result_o, 64'd0);
        chk("reset.ready", 64'(bus.ready_o), 64'd0);
        bus.start_i = 1'b1;
        #1;
        chk("reset.stall", 64'(bus.stall_req_o), 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        do_div("udiv_100_7",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32);
        do_div("sdiv_m7_2",    1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 32);
        do_div("udiv_m7_2",    1'b0, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC, 32);
        do_div("div_zero",     1'b1, 32'd1234,       32'd0,          64'h0,                 1);
        do_div("sdiv_minint",  1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 32);
        do_div("sdiv_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 32);
        do_div("sdiv_m100_m7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 32);
        do_div("udiv_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 32);
        do_div("udiv_5_9",     1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 32);

        // Annul in the middle of an iteration
        bus.start_i      = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        #1;
        chk("annul.stall", 64'(bus.stall_req_o), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) rises++;
        end
        chk("annul.no_ready", 64'(rises), 64'd0);
        chk("annul.result", bus.result_o, 64'd0);
        chk("annul.idle_stall", 64'(bus.stall_req_o), 64'd0);
        @(negedge clk);
        do_div("after_annul", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 32);

        // Asynchronous reset while iterating, then restart right after release
        bus.start_i      = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd77;
        bus.opdata2_i    = 32'd5;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid.result", bus.result_o, 64'd0);
        chk("rst_mid.ready", 64'(bus.ready_o), 64'd0);
        chk("rst_mid.stall", 64'(bus.stall_req_o), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_mid.held", {bus.result_o[62:0], bus.ready_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_div("after_rst", 1'b0, 32'd77, 32'd5, 64'h00000002_0000000F, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
